serial_onehot_scatter_signed_16_outputs: RTL and testbench



---
 rtl/serial_onehot_scatter_signed_16_outputs.sv | 104 ++++++++++
 tb/tb_serial_onehot_scatter_signed_16_outputs.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_onehot_scatter_signed_16_outputs.sv
// Expands one (index, value) pair into a one-hot vector of NUM_CHUNKS*16 signed
// lanes, streamed as 16-lane chunks with valid/ready backpressure.
module serial_onehot_scatter_signed_16_outputs #(
    parameter int WIDTH        = 8,
    parameter int ARGMAX_WIDTH = 8,
    parameter int NUM_CHUNKS   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ARGMAX_WIDTH-1:0] in_argmax,
    input  logic signed [WIDTH-1:0] in_value,
    output logic signed [WIDTH-1:0] out [16],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ARGMAX_WIDTH-5:0] out_chunk,
    output logic                    out_last,
    output logic                    error
);

    localparam int          CW        = ARGMAX_WIDTH - 4;
    localparam int unsigned NUM_ELEMS = NUM_CHUNKS * 16;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  state, state_next;
    logic [CW-1:0]           chunk_cnt, chunk_cnt_next;
    logic [ARGMAX_WIDTH-1:0] idx_q;
    logic signed [WIDTH-1:0] value_q;
    logic                    accept;
    logic                    in_range;
    logic                    is_last;
    logic                    error_next;

    assign accept   = in_valid && in_ready;
    assign in_range = 32'(in_argmax) < NUM_ELEMS;
    assign is_last  = chunk_cnt == CW'(NUM_CHUNKS - 1);

    // NOTE: every output of this process gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        chunk_cnt_next = chunk_cnt;
        error_next     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_next     = STREAM;
                        chunk_cnt_next = '0;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (is_last) state_next = IDLE;
                    else         chunk_cnt_next = chunk_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            chunk_cnt <= '0;
            idx_q     <= '0;
            value_q   <= '0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            chunk_cnt <= chunk_cnt_next;
            error     <= error_next;
            if (accept && in_range) begin
                idx_q   <= in_argmax;
                value_q <= in_value;
            end
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == STREAM;
    assign out_last  = out_valid && is_last;
    // chunk_cnt is left at its last value after a vector, so gate it in IDLE.
    assign out_chunk = out_valid ? chunk_cnt : '0;

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            out[k] = '0;
            if (out_valid && chunk_cnt == idx_q[ARGMAX_WIDTH-1:4] && idx_q[3:0] == 4'(k))
                out[k] = value_q;
        end
    end

endmodule

// File: tb/tb_serial_onehot_scatter_signed_16_outputs.sv
// Scoreboard bench: a 16-chunk and a 4-chunk instance, driven with directed and
// random pairs; a monitor per instance checks each presented chunk.
module tb_serial_onehot_scatter_signed_16_outputs;

    localparam int NC_A = 16;
    localparam int NC_B = 4;

    typedef struct packed {
        logic [3:0]        chunk;
        logic              last;
        logic [15:0][7:0]  lanes;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, error_a;
    logic [7:0]        in_argmax_a;
    logic signed [7:0] in_value_a;
    logic signed [7:0] out_a [16];
    logic [3:0]        out_chunk_a;

    logic              in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, error_b;
    logic [7:0]        in_argmax_b;
    logic signed [7:0] in_value_b;
    logic signed [7:0] out_b [16];
    logic [3:0]        out_chunk_b;

    serial_onehot_scatter_signed_16_outputs #(.WIDTH(8), .ARGMAX_WIDTH(8), .NUM_CHUNKS(NC_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_argmax(in_argmax_a), .in_value(in_value_a), .out(out_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_chunk(out_chunk_a),
        .out_last(out_last_a), .error(error_a)
    );

    serial_onehot_scatter_signed_16_outputs #(.WIDTH(8), .ARGMAX_WIDTH(8), .NUM_CHUNKS(NC_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_argmax(in_argmax_b), .in_value(in_value_b), .out(out_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_chunk(out_chunk_b),
        .out_last(out_last_b), .error(error_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   xfer_a = 0;
    int   xfer_b = 0;
    bit   bp_a = 1'b0;
    bit   bp_b = 1'b0;

    task automatic check(input string name, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic signed [7:0] v [16]);
        logic [15:0][7:0] r;
        for (int k = 0; k < 16; k++) r[k] = v[k];
        return r;
    endfunction

    // Reference model: build the whole one-hot vector, then slice it into chunks.
    task automatic push_vector(input bit sel, input int idx, input logic signed [7:0] val);
        int                nc = sel ? NC_B : NC_A;
        logic signed [7:0] vec [];
        exp_t              e;
        vec = new[nc * 16];
        foreach (vec[i]) vec[i] = 8'sd0;
        vec[idx] = val;
        for (int c = 0; c < nc; c++) begin
            e.chunk = 4'(c);
            e.last  = (c == nc - 1);
            for (int k = 0; k < 16; k++) e.lanes[k] = vec[c * 16 + k];
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send(input bit sel, input int idx, input logic signed [7:0] val);
        int nc     = sel ? NC_B : NC_A;
        bit ok     = idx < nc * 16;
        int waited = 0;
        bit timed_out = 1'b0;
        if (sel) begin in_valid_b = 1'b1; in_argmax_b = 8'(idx); in_value_b = val; end
        else     begin in_valid_a = 1'b1; in_argmax_a = 8'(idx); in_value_a = val; end
        while (!(sel ? in_ready_b : in_ready_a)) begin
            if (waited++ > 300) begin
                check("accept_timeout", 0, 1);
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!timed_out && ok) push_vector(sel, idx, val);
        @(posedge clk); #1;
        if (sel) in_valid_b = 1'b0;
        else     in_valid_a = 1'b0;
        if (timed_out) return;
        @(negedge clk);
        check(sel ? "b_error_pulse" : "a_error_pulse", sel ? error_b : error_a, !ok);
        if (!ok) begin
            check("b_no_valid_on_error", out_valid_b, 0);
            @(negedge clk);
            check("b_error_one_cycle", error_b, 0);
            check("b_ready_after_error", in_ready_b, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input bit sel);
        int waited = 0;
        while (!((sel ? q_b.size() : q_a.size()) == 0 && (sel ? in_ready_b : in_ready_a))) begin
            if (waited++ > 3000) begin
                check("drain_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        out_ready_a = bp_a ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready_b = bp_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        logic [127:0] g;
        exp_t         e;
        if (rst) begin
            g = pack(out_a);
            if (out_valid_a) begin
                if (q_a.size() == 0) check("a_spurious_valid", out_valid_a, 0);
                else begin
                    e = q_a[0];
                    check("a_out_chunk", out_chunk_a, e.chunk);
                    check("a_out_lanes", g, e.lanes);
                    check("a_out_last", out_last_a, e.last);
                    check("a_in_ready_busy", in_ready_a, 0);
                    if (out_ready_a) begin
                        void'(q_a.pop_front());
                        xfer_a++;
                    end
                end
            end else
                check("a_idle_outputs", {g, out_chunk_a, out_last_a, in_ready_a}, {128'd0, 4'd0, 1'b0, 1'b1});
        end
    end

    always @(negedge clk) begin
        logic [127:0] g;
        exp_t         e;
        if (rst) begin
            g = pack(out_b);
            if (out_valid_b) begin
                if (q_b.size() == 0) check("b_spurious_valid", out_valid_b, 0);
                else begin
                    e = q_b[0];
                    check("b_out_chunk", out_chunk_b, e.chunk);
                    check("b_out_lanes", g, e.lanes);
                    check("b_out_last", out_last_b, e.last);
                    check("b_in_ready_busy", in_ready_b, 0);
                    if (out_ready_b) begin
                        void'(q_b.pop_front());
                        xfer_b++;
                    end
                end
            end else
                check("b_idle_outputs", {g, out_chunk_b, out_last_b, in_ready_b}, {128'd0, 4'd0, 1'b0, 1'b1});
        end
    end

    initial begin
        int base;
        int waited;
        rst = 1'b0;
        in_valid_a = 1'b0; in_argmax_a = '0; in_value_a = '0;
        in_valid_b = 1'b0; in_argmax_b = '0; in_value_b = '0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;

        repeat (2) @(posedge clk); #1;
        check("rst_a_state", {in_ready_a, out_valid_a, out_last_a, error_a}, 4'b1000);
        check("rst_a_out", pack(out_a), 0);
        check("rst_b_state", {in_ready_b, out_valid_b, out_last_b, error_b}, 4'b1000);
        check("rst_b_out", pack(out_b), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("idle_a_state", {in_ready_a, out_valid_a, error_a}, 3'b100);
        check("idle_b_state", {in_ready_b, out_valid_b, error_b}, 3'b100);

        base = xfer_a;
        send(0, 37, -8'sd5);
        drain(0);
        check("basic_transfer_count", xfer_a - base, 16);

        bp_a = 1'b1;
        base = xfer_a;
        send(0, 37, -8'sd5);
        drain(0);
        check("bp_transfer_count", xfer_a - base, 16);
        bp_a = 1'b0;

        send(1, 64, 8'sd17);
        check("oor_no_queue", q_b.size(), 0);
        base = xfer_b;
        send(1, 63, 8'sd127);
        drain(1);
        check("b_transfer_count", xfer_b - base, 4);

        send(0, 0, -8'sd128);
        drain(0);
        send(0, 255, 8'sd1);
        drain(0);
        base = xfer_a;
        send(0, 16, 8'sd0);
        for (int i = 0; i < 3; i++) begin
            in_valid_a  = 1'b1;
            in_argmax_a = 8'($urandom);
            in_value_a  = 8'($urandom_range(1, 100));
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        drain(0);
        check("ignored_pulses_count", xfer_a - base, 16);

        for (int i = 0; i < 12; i++) begin
            bp_a = 1'($urandom_range(0, 1));
            send(0, int'($urandom_range(0, 255)), 8'($urandom));
            drain(0);
            bp_b = 1'($urandom_range(0, 1));
            send(1, int'($urandom_range(0, 79)), 8'($urandom));
            drain(1);
        end
        bp_a = 1'b0;
        bp_b = 1'b0;
        repeat (2) @(posedge clk); #1;

        base = xfer_a;
        send(0, 120, 8'sd42);
        waited = 0;
        while (xfer_a - base < 7) begin
            if (waited++ > 100) begin
                check("mid_reset_wait_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        check("mid_reset_at_chunk7", out_chunk_a, 7);
        #1 rst = 1'b0;
        q_a.delete();
        #1;
        check("mid_reset_valid_drop", out_valid_a, 0);
        check("mid_reset_out_zero", pack(out_a), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("after_reset_ready", in_ready_a, 1);
        base = xfer_a;
        send(0, 200, -8'sd77);
        drain(0);
        check("after_reset_transfer_count", xfer_a - base, 16);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
